// File: rtl/pipo_universal.sv
// WIDTH-bit universal register (hold/load/shift right/shift left) with an autonomous N-position burst engine.
// Optional rotate support is compiled in when PIPO_ROTATE_EN is defined (adds the i_rot input).
module pipo_universal #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ser_msb,
  input  logic             i_ser_lsb,
`ifdef PIPO_ROTATE_EN
  input  logic             i_rot,
`endif
  input  logic             i_start,
  input  logic [CW-1:0]    i_count,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ser_msb,
  output logic             o_ser_lsb,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [1:0]    MODE_LOAD = 2'b01;
  localparam logic [1:0]    MODE_SHR  = 2'b10;
  localparam logic [1:0]    MODE_SHL  = 2'b11;
  localparam logic [CW-1:0] MAX_CNT   = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir_left, dir_left_nxt;
  logic             rot_q, rot_nxt;
  logic             done_q, done_nxt;
  logic             rot_in;

`ifdef PIPO_ROTATE_EN
  assign rot_in = i_rot;
`else
  assign rot_in = 1'b0;
`endif

  // With rot set, the bit falling off one end re-enters at the other instead of the serial input.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w,
                                                  input logic left, input logic rot,
                                                  input logic ser_msb, input logic ser_lsb);
    if (left) return {w[WIDTH-2:0], (rot ? w[WIDTH-1] : ser_lsb)};
    else      return {(rot ? w[0] : ser_msb), w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      data_q   <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
      rot_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_q   <= data_nxt;
      cnt      <= cnt_nxt;
      dir_left <= dir_left_nxt;
      rot_q    <= rot_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_nxt     = data_q;
    cnt_nxt      = cnt;
    dir_left_nxt = dir_left;
    rot_nxt      = rot_q;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        // A start request always blocks the per-cycle mode, even when it is ignored.
        if (i_start) begin
          if (i_mode[1]) begin
            if (i_count == '0) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt    = BURST;
              dir_left_nxt = i_mode[0];
              rot_nxt      = rot_in;
              cnt_nxt      = (i_count > MAX_CNT) ? MAX_CNT : i_count;
            end
          end
        end else if (enb) begin
          case (i_mode)
            MODE_LOAD: data_nxt = i_data;
            MODE_SHR:  data_nxt = shift_word(data_q, 1'b0, rot_in, i_ser_msb, i_ser_lsb);
            MODE_SHL:  data_nxt = shift_word(data_q, 1'b1, rot_in, i_ser_msb, i_ser_lsb);
            default:   data_nxt = data_q;
          endcase
        end
      end
      BURST: begin
        if (enb) begin
          data_nxt = shift_word(data_q, dir_left, rot_q, i_ser_msb, i_ser_lsb);
          cnt_nxt  = cnt - ONE_CNT;
          if (cnt == ONE_CNT) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_data    = data_q;
  assign o_ser_msb = data_q[WIDTH-1];
  assign o_ser_lsb = data_q[0];
  assign o_busy    = (state == BURST);
  assign o_done    = done_q;

endmodule
